// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority-voted bit decisions,
// optional parity, 1 or 2 stop bits, break detection and a valid/ready
// output holding register with overrun reporting.
module uart_rx_os #(
  parameter int unsigned CLK_RATE   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 RX_I,
  output logic [DATA_BITS-1:0] DATA_O,
  output logic                 VALID_O,
  input  logic                 READY_I,
  output logic                 PARITY_ERR_O,
  output logic                 FRAME_ERR_O,
  output logic                 BREAK_O,
  output logic                 OVERRUN_O,
  output logic                 BUSY_O
);

  localparam int unsigned DIV   = (CLK_RATE + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned S0    = OVERSAMPLE / 2 - 1;
  localparam int unsigned S1    = OVERSAMPLE / 2;
  localparam int unsigned S2    = OVERSAMPLE / 2 + 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_PAR      = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;
  localparam logic [2:0] ST_BRK_WAIT = 3'd5;

  // Elaboration-time parameter legality checks
  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_os: sample divisor must be at least 2");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE > 32) || ((OVERSAMPLE % 2) != 0)) begin : g_os_chk
    $error("uart_rx_os: OVERSAMPLE must be even and within 8..32");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_db_chk
    $error("uart_rx_os: DATA_BITS must be within 5..9");
  end
  if (PARITY > 2) begin : g_par_chk
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_stop_chk
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end

  // Receive-side state
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]      samp_cnt_q, samp_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 all_zero_q, all_zero_d;

  // Output holding register
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  // Per-cycle decode helpers
  logic fall_c, tick_c, vote_c, voted_c;
  logic done_c, done_ferr_c, done_brk_c;
  logic frm_err_nx_c, all_zero_nx_c;

  // Two-flop synchroniser plus edge-detect history, all idling high
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX_I;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      samp_cnt_q <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      all_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      smp_q      <= smp_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      all_zero_q <= all_zero_d;
    end
  end

  // Tick generation, sampling, voting and frame sequencing
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    samp_cnt_d    = samp_cnt_q;
    smp_d         = smp_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    shift_d       = shift_q;
    par_err_d     = par_err_q;
    frm_err_d     = frm_err_q;
    all_zero_d    = all_zero_q;
    done_c        = 1'b0;
    done_ferr_c   = 1'b0;
    done_brk_c    = 1'b0;
    frm_err_nx_c  = frm_err_q;
    all_zero_nx_c = all_zero_q;

    fall_c  = rx_prev_q & ~rx_sync_q;
    tick_c  = (state_q != ST_IDLE) && (div_cnt_q == CNT_W'(DIV - 1));
    vote_c  = tick_c && (samp_cnt_q == OS_W'(S2));
    voted_c = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);

    // Bit timing restarts from zero every time the receiver leaves IDLE
    if (state_q == ST_IDLE) begin
      div_cnt_d  = '0;
      samp_cnt_d = '0;
    end else if (tick_c) begin
      div_cnt_d  = '0;
      samp_cnt_d = (samp_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt_q + OS_W'(1);
    end else begin
      div_cnt_d  = div_cnt_q + CNT_W'(1);
    end

    if (tick_c && (samp_cnt_q == OS_W'(S0))) smp_d[0] = rx_sync_q;
    if (tick_c && (samp_cnt_q == OS_W'(S1))) smp_d[1] = rx_sync_q;

    case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d    = ST_START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
          all_zero_d = 1'b1;
        end
      end
      ST_START: begin
        if (vote_c) state_d = voted_c ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (vote_c) begin
          shift_d    = {voted_c, shift_q[DATA_BITS-1:1]};
          all_zero_d = all_zero_q & ~voted_c;
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (vote_c) begin
          par_err_d  = (PARITY == 1) ? ~(^shift_q ^ voted_c) : (^shift_q ^ voted_c);
          all_zero_d = all_zero_q & ~voted_c;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (vote_c) begin
          frm_err_nx_c = frm_err_q | ~voted_c;
          all_zero_nx_c = all_zero_q & ~voted_c;
          frm_err_d    = frm_err_nx_c;
          all_zero_d   = all_zero_nx_c;
          stop_cnt_d   = stop_cnt_q + 1'b1;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_c      = 1'b1;
            done_brk_c  = all_zero_nx_c;
            done_ferr_c = frm_err_nx_c | all_zero_nx_c;
            state_d     = all_zero_nx_c ? ST_BRK_WAIT : ST_IDLE;
          end
        end
      end
      ST_BRK_WAIT: begin
        // Leave only after the line has stayed high for one whole bit time
        if (!rx_sync_q) begin
          samp_cnt_d = '0;
        end else if (tick_c && (samp_cnt_q == OS_W'(OVERSAMPLE - 1))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output holding register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Load a completed frame unless an unconsumed one is held; else flag overrun
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    ovr_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);

    if (valid_q && READY_I) valid_d = 1'b0;

    if (done_c) begin
      if (!valid_q || READY_I) begin
        data_d  = shift_q;
        perr_d  = par_err_q;
        ferr_d  = done_ferr_c;
        brk_d   = done_brk_c;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign DATA_O       = data_q;
  assign VALID_O      = valid_q;
  assign PARITY_ERR_O = perr_q;
  assign FRAME_ERR_O  = ferr_q;
  assign BREAK_O      = brk_q;
  assign OVERRUN_O    = ovr_q;
  assign BUSY_O       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed checks of the oversampling UART receiver at
// 160 clocks per bit (8N1 instance plus an 8E1 instance for parity).
module tb_uart_rx_os;

  localparam int unsigned CLK_RATE = 1600000;
  localparam int unsigned BAUD     = 10000;
  localparam int unsigned OS       = 16;
  localparam int          BIT_CYC  = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic ready = 1'b1;
  logic rx_ep = 1'b1;
  logic ready_ep = 1'b1;

  logic [7:0] data_o, ep_data_o;
  logic valid_o, perr_o, ferr_o, brk_o, ovr_o, busy_o;
  logic ep_valid_o, ep_perr_o, ep_ferr_o, ep_brk_o, ep_ovr_o, ep_busy_o;

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
               .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut (
    .CLK_I(clk), .RST_I(rst), .RX_I(rx), .DATA_O(data_o), .VALID_O(valid_o),
    .READY_I(ready), .PARITY_ERR_O(perr_o), .FRAME_ERR_O(ferr_o),
    .BREAK_O(brk_o), .OVERRUN_O(ovr_o), .BUSY_O(busy_o)
  );

  uart_rx_os #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
               .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_ep (
    .CLK_I(clk), .RST_I(rst), .RX_I(rx_ep), .DATA_O(ep_data_o), .VALID_O(ep_valid_o),
    .READY_I(ready_ep), .PARITY_ERR_O(ep_perr_o), .FRAME_ERR_O(ep_ferr_o),
    .BREAK_O(ep_brk_o), .OVERRUN_O(ep_ovr_o), .BUSY_O(ep_busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transfer monitor: records every accepted frame and output activity
  int rx_cnt = 0, vld_cyc = 0, ovr_cnt = 0, ep_rx_cnt = 0;
  logic [7:0] last_data = 8'h00, ep_last_data = 8'h00;
  logic last_perr = 1'b0, last_ferr = 1'b0, last_brk = 1'b0, ep_last_perr = 1'b0;

  always @(negedge clk) begin
    if (valid_o && ready) begin
      rx_cnt    = rx_cnt + 1;
      last_data = data_o;
      last_perr = perr_o;
      last_ferr = ferr_o;
      last_brk  = brk_o;
    end
    if (valid_o) vld_cyc = vld_cyc + 1;
    if (ovr_o) ovr_cnt = ovr_cnt + 1;
    if (ep_valid_o && ready_ep) begin
      ep_rx_cnt    = ep_rx_cnt + 1;
      ep_last_data = ep_data_o;
      ep_last_perr = ep_perr_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(BIT_CYC);
    end
    rx = 1'b1;
    wait_cyc(BIT_CYC);
  endtask

  task automatic send_frame_ep(input logic [7:0] d, input logic p);
    rx_ep = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx_ep = d[i];
      wait_cyc(BIT_CYC);
    end
    rx_ep = p;
    wait_cyc(BIT_CYC);
    rx_ep = 1'b1;
    wait_cyc(BIT_CYC);
  endtask

  int c0, v0, o0;

  initial begin
    // Reset state
    wait_cyc(5);
    check_eq("rst_data", 32'(data_o), 32'h0);
    check_eq("rst_valid", 32'(valid_o), 32'h0);
    check_eq("rst_flags", 32'({perr_o, ferr_o, brk_o, ovr_o}), 32'h0);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
    rst = 1'b0;
    wait_cyc(20);

    // 8N1 frame 0xA5 with consumer always ready
    c0 = rx_cnt; v0 = vld_cyc;
    send_frame(8'hA5);
    wait_cyc(BIT_CYC);
    check_eq("a5_count", 32'(rx_cnt - c0), 32'd1);
    check_eq("a5_data", 32'(last_data), 32'hA5);
    check_eq("a5_flags", 32'({last_perr, last_ferr, last_brk}), 32'h0);
    check_eq("a5_valid_cycles", 32'(vld_cyc - v0), 32'd1);
    check_eq("a5_no_overrun", 32'(ovr_cnt), 32'd0);

    // Even parity: 0x07 needs parity bit 1; send 0 first, then 1
    send_frame_ep(8'h07, 1'b0);
    wait_cyc(BIT_CYC);
    check_eq("ep_bad_count", 32'(ep_rx_cnt), 32'd1);
    check_eq("ep_bad_data", 32'(ep_last_data), 32'h07);
    check_eq("ep_bad_perr", 32'(ep_last_perr), 32'd1);
    send_frame_ep(8'h07, 1'b1);
    wait_cyc(BIT_CYC);
    check_eq("ep_good_count", 32'(ep_rx_cnt), 32'd2);
    check_eq("ep_good_perr", 32'(ep_last_perr), 32'd0);

    // 40-cycle glitch: start is rejected, receiver returns to idle
    c0 = rx_cnt;
    rx = 1'b0;
    wait_cyc(40);
    rx = 1'b1;
    check_eq("glitch_busy_hi", 32'(busy_o), 32'd1);
    for (int i = 0; i < 100 && busy_o; i++) wait_cyc(1);
    check_eq("glitch_busy_lo", 32'(busy_o), 32'd0);
    wait_cyc(2 * BIT_CYC);
    check_eq("glitch_no_frame", 32'(rx_cnt - c0), 32'd0);

    // Break: line low for 20 bit times, then a normal frame
    c0 = rx_cnt;
    rx = 1'b0;
    wait_cyc(20 * BIT_CYC);
    rx = 1'b1;
    wait_cyc(3 * BIT_CYC);
    check_eq("brk_count", 32'(rx_cnt - c0), 32'd1);
    check_eq("brk_flag", 32'(last_brk), 32'd1);
    check_eq("brk_ferr", 32'(last_ferr), 32'd1);
    check_eq("brk_data", 32'(last_data), 32'h00);
    check_eq("brk_idle", 32'(busy_o), 32'd0);
    send_frame(8'h3C);
    wait_cyc(BIT_CYC);
    check_eq("post_brk_count", 32'(rx_cnt - c0), 32'd2);
    check_eq("post_brk_data", 32'(last_data), 32'h3C);
    check_eq("post_brk_flags", 32'({last_perr, last_ferr, last_brk}), 32'h0);

    // Back-to-back frames with consumer stalled: second frame overruns
    ready = 1'b0;
    c0 = rx_cnt; o0 = ovr_cnt;
    send_frame(8'h11);
    send_frame(8'h22);
    wait_cyc(BIT_CYC);
    check_eq("ovr_valid", 32'(valid_o), 32'd1);
    check_eq("ovr_held_data", 32'(data_o), 32'h11);
    check_eq("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check_eq("ovr_no_xfer", 32'(rx_cnt - c0), 32'd0);
    ready = 1'b1;
    wait_cyc(1);
    check_eq("ovr_valid_clr", 32'(valid_o), 32'd0);
    check_eq("ovr_xfer_data", 32'(last_data), 32'h11);

    // Reset in the middle of data bit 4 of 0xFF
    c0 = rx_cnt;
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    rx = 1'b1;
    wait_cyc(4 * BIT_CYC + 80);
    check_eq("mid_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
    check_eq("mid_rst_data", 32'(data_o), 32'h0);
    check_eq("mid_rst_out", 32'({valid_o, perr_o, ferr_o, brk_o, ovr_o}), 32'h0);
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(5 * BIT_CYC);
    check_eq("post_rst_idle", 32'(busy_o), 32'd0);
    check_eq("post_rst_no_frame", 32'(rx_cnt - c0), 32'd0);
    send_frame(8'h5A);
    wait_cyc(BIT_CYC);
    check_eq("post_rst_count", 32'(rx_cnt - c0), 32'd1);
    check_eq("post_rst_data", 32'(last_data), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The module SHALL have parameter CLK_RATE, default 100000000, meaning the system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 115200, meaning the line bit rate in baud.
REQ-003 The module SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit; legal values are even numbers from 8 to 32.
REQ-004 The module SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values are 5 to 9.
REQ-005 The module SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-006 The module SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 and 2.
REQ-007 CLK_I  input  1  SHALL be the single clock; all flops update on its rising edge.
REQ-008 RST_I  input  1  SHALL be the reset: asynchronous, active-high.
REQ-009 RX_I  input  1  SHALL be the asynchronous serial line, idle high.
REQ-010 DATA_O  output  DATA_BITS  SHALL carry the received data, LSB first on the wire.
REQ-011 VALID_O  output  1  SHALL be high while DATA_O and the error flags hold an unconsumed frame.
REQ-012 READY_I  input  1  SHALL mean the consumer accepts the frame; a transfer occurs when VALID_O and READY_I are both high.
REQ-013 PARITY_ERR_O, FRAME_ERR_O, BREAK_O  output  1 each  SHALL be status flags qualified by VALID_O.
REQ-014 OVERRUN_O  output  1  SHALL be a one-cycle pulse signalling that a frame was dropped.
REQ-015 BUSY_O  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 RX_I SHALL pass through a 2-flop synchroniser initialised to 1; all decoding SHALL use the synchronised signal.
REQ-017 The sample-tick divisor SHALL be DIV = (CLK_RATE + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), i.e. rounded, and SHALL be at least 2 (elaboration assertion).
REQ-018 The tick counter SHALL have width $clog2(DIV), restart when it leaves IDLE, and assert one tick every DIV cycles.
REQ-019 Each bit SHALL be resolved by a 2-of-3 majority vote of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
REQ-020 States SHALL be IDLE, START, DATA, PAR, STOP, BRK_WAIT.
REQ-021 IDLE -> START SHALL occur on a synchronised falling edge.
REQ-022 At the end of START, a voted 1 SHALL be treated as a glitch: return to IDLE, no output.
REQ-023 DATA SHALL shift DATA_BITS bits LSB first, then go to PAR if PARITY != 0, else to STOP.
REQ-024 PAR SHALL check the voted bit: odd means the XOR of data and parity is 1; even means it is 0.
REQ-025 STOP SHALL check STOP_BITS bits; any voted 0 SHALL set the frame error.
REQ-026 A frame with all data, parity and stop bits 0 SHALL set BREAK and FRAME_ERR, then enter BRK_WAIT until the synchronised line is 1 for a full bit time, then go to IDLE.
REQ-027 Frame completion SHALL be the last stop-bit vote; the next falling edge SHALL be accepted from the following cycle, with no idle gap required.
REQ-028 On completion with VALID_O low, or with VALID_O and READY_I both high in the same cycle: DATA_O and the flags SHALL load and VALID_O SHALL be 1 on the next cycle.
REQ-029 On completion with VALID_O high and READY_I low: the held frame SHALL be kept, the new frame dropped, and OVERRUN_O pulsed one cycle.
REQ-030 VALID_O SHALL clear on the cycle after a transfer unless a new frame loads in that same cycle.
REQ-031 DATA_O and the flags SHALL remain stable while VALID_O is high and READY_I is low.

Reset
REQ-032 While RST_I is high, the module SHALL force state IDLE, counters 0, synchroniser 1, DATA_O 0, and VALID_O, all flags, OVERRUN_O and BUSY_O 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; after release, the module SHALL wait for a fresh falling edge.

Verification (CLK_RATE=1600000, BAUD_RATE=10000, OVERSAMPLE=16, so DIV=10 and 160 cycles/bit)
REQ-034 8N1 frame 0xA5, READY_I=1 -> VALID_O one cycle with DATA_O=0xA5, all flags 0.
REQ-035 PARITY=2, frame 0x07 with parity bit 0 -> DATA_O=0x07, PARITY_ERR_O=1.
REQ-036 Low pulse of 40 cycles on an idle line -> no VALID_O, BUSY_O back to 0 within 100 cycles.
REQ-037 Line held low for 20 bit times -> BREAK_O=1, FRAME_ERR_O=1, DATA_O=0x00; next valid frame 0x3C received correctly after the line returns high.
REQ-038 Two back-to-back frames 0x11, 0x22 with READY_I=0 -> DATA_O stays 0x11, OVERRUN_O pulses once; READY_I=1 then clears VALID_O.
REQ-039 RST_I asserted at data bit 4 of 0xFF -> outputs zero immediately; frame 0x5A sent after release is received correctly.
